// File: rtl/axi_skid_buffer.sv
// axi_skid_buffer
// Two-entry register slice (output register + skid register) between an
// upstream ready/valid master and a downstream slave. i_ready, o_valid and
// o_data all come straight from flops, so no combinational path crosses the
// slice. Sustains one beat per cycle with one cycle of latency; a beat that
// arrives while the output is stalled is parked in the skid register.
//
// Ports
//   aclk          clock, rising edge
//   aresetn       asynchronous reset, active-high
//   i_valid       upstream beat valid
//   i_data        upstream payload [WIDTH-1:0]
//   i_ready       slice can accept a beat (registered)
//   o_valid       downstream beat valid (registered)
//   o_data        downstream payload [WIDTH-1:0] (registered)
//   o_ready       downstream accepts
//   stat_in_cnt   input handshake count   (SKID_STATS_EN only)
//   stat_out_cnt  output handshake count  (SKID_STATS_EN only)
//   stat_skid_cnt skid capture count      (SKID_STATS_EN only)
//
// Build option: define SKID_STATS_EN to add the three wrapping 32-bit
// handshake counters. The datapath is identical with or without it.

module axi_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             o_ready
`ifdef SKID_STATS_EN
  ,
  output logic [31:0]      stat_in_cnt,
  output logic [31:0]      stat_out_cnt,
  output logic [31:0]      stat_skid_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  // State is the pair {o_valid_q, skid_valid_q}: EMPTY(0,0), ONE(1,0), FULL(1,1).
  logic             o_valid_q,    o_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] o_data_q,     o_data_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             i_ready_q,    i_ready_d;

  logic acc;
  logic out_free;
  logic out_hs;
  logic skid_cap;

  // State register.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      o_valid_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      o_data_q     <= '0;
      skid_data_q  <= '0;
      i_ready_q    <= 1'b0;
    end else begin
      o_valid_q    <= o_valid_d;
      skid_valid_q <= skid_valid_d;
      o_data_q     <= o_data_d;
      skid_data_q  <= skid_data_d;
      i_ready_q    <= i_ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    o_valid_d    = o_valid_q;
    skid_valid_d = skid_valid_q;
    o_data_d     = o_data_q;
    skid_data_d  = skid_data_q;

    // i_ready_q is low in FULL, so acceptance and a skid flush never coincide.
    acc      = i_valid & i_ready_q;
    out_free = ~o_valid_q | o_ready;
    out_hs   = o_valid_q & o_ready;
    skid_cap = ~out_free & acc;

    if (out_free) begin
      if (skid_valid_q) begin
        o_data_d     = skid_data_q;
        o_valid_d    = 1'b1;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        o_data_d  = i_data;
        o_valid_d = 1'b1;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (acc) begin
      // Output stalled: park the new beat, output holds.
      skid_data_d  = i_data;
      skid_valid_d = 1'b1;
    end

    // Look at the next skid state so i_ready drops the cycle after a capture.
    i_ready_d = ~skid_valid_d;
  end

  // Outputs.
  always_comb begin
    i_ready = i_ready_q;
    o_valid = o_valid_q;
    o_data  = o_data_q;
  end

`ifdef SKID_STATS_EN
  logic [CNT_W-1:0] stat_in_cnt_q,   stat_in_cnt_d;
  logic [CNT_W-1:0] stat_out_cnt_q,  stat_out_cnt_d;
  logic [CNT_W-1:0] stat_skid_cnt_q, stat_skid_cnt_d;

  // Statistics counter registers.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      stat_in_cnt_q   <= '0;
      stat_out_cnt_q  <= '0;
      stat_skid_cnt_q <= '0;
    end else begin
      stat_in_cnt_q   <= stat_in_cnt_d;
      stat_out_cnt_q  <= stat_out_cnt_d;
      stat_skid_cnt_q <= stat_skid_cnt_d;
    end
  end

  // Counters wrap naturally at 2^32.
  always_comb begin
    stat_in_cnt_d   = stat_in_cnt_q;
    stat_out_cnt_d  = stat_out_cnt_q;
    stat_skid_cnt_d = stat_skid_cnt_q;
    if (acc)      stat_in_cnt_d   = stat_in_cnt_q   + CNT_W'(1);
    if (out_hs)   stat_out_cnt_d  = stat_out_cnt_q  + CNT_W'(1);
    if (skid_cap) stat_skid_cnt_d = stat_skid_cnt_q + CNT_W'(1);
  end

  always_comb begin
    stat_in_cnt   = stat_in_cnt_q;
    stat_out_cnt  = stat_out_cnt_q;
    stat_skid_cnt = stat_skid_cnt_q;
  end
`else
  // Handshake terms only feed the statistics counters.
  logic unused_stats;
  assign unused_stats = out_hs ^ skid_cap;
`endif

endmodule

// File: tb/tb_axi_skid_buffer.sv
// Testbench for axi_skid_buffer: directed scenarios plus a randomized run
// checked against a FIFO-of-beats model (capacity two, one cycle latency).

module tb_axi_skid_buffer;

  logic        aclk;
  logic        aresetn;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_ready;
`ifdef SKID_STATS_EN
  logic [31:0] stat_in_cnt;
  logic [31:0] stat_out_cnt;
  logic [31:0] stat_skid_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: beats held inside the slice, oldest first.
  logic [31:0] mq[$];
  bit          started;
  int unsigned m_in, m_out, m_skid;

  axi_skid_buffer #(.WIDTH(32)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready)
`ifdef SKID_STATS_EN
    ,
    .stat_in_cnt   (stat_in_cnt),
    .stat_out_cnt  (stat_out_cnt),
    .stat_skid_cnt (stat_skid_cnt)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Slice accepts whenever it holds fewer than two beats (after the first edge).
  function automatic bit exp_ready();
    return started && (mq.size() < 2);
  endfunction

  // Advance one clock and update the model from the pre-edge inputs.
  task automatic cycle();
    bit acc, ohs, stall;
    logic [31:0] d;
    acc   = i_valid && exp_ready();
    ohs   = (mq.size() != 0) && o_ready;
    stall = (mq.size() != 0) && !o_ready;
    d     = i_data;
    @(posedge aclk);
    #1;
    if (ohs) begin mq.delete(0); m_out++; end
    if (acc) begin mq.push_back(d); m_in++; if (stall) m_skid++; end
    started = 1'b1;
  endtask

  task automatic model_clear();
    mq.delete();
    started = 1'b0;
    m_in = 0; m_out = 0; m_skid = 0;
  endtask

  task automatic test_reset();
    aresetn = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
    model_clear();
    #20;
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    tests_run++; if (o_data !== 32'h0) begin tests_failed++; $display("FAIL reset_o_data: got %h expected 00000000", o_data); end
    tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_i_ready: got %b expected 0", i_ready); end
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL release_i_ready_pre_edge: got %b expected 0", i_ready); end
    cycle();
    tests_run++; if (i_ready !== 1'b1) begin tests_failed++; $display("FAIL release_i_ready_post_edge: got %b expected 1", i_ready); end
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL release_o_valid: got %b expected 0", o_valid); end
  endtask

  task automatic test_single();
    o_ready = 1'b1; i_valid = 1'b1; i_data = 32'hAADD1234;
    cycle();
    i_valid = 1'b0; i_data = '0;
    tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", o_valid); end
    tests_run++; if (o_data !== 32'hAADD1234) begin tests_failed++; $display("FAIL single_data: got %h expected aadd1234", o_data); end
    cycle();
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got %b expected 0", o_valid); end
    tests_run++; if (o_data !== 32'hAADD1234) begin tests_failed++; $display("FAIL single_hold: got %h expected aadd1234", o_data); end
  endtask

  task automatic test_stall_capture();
    o_ready = 1'b1; i_valid = 1'b1; i_data = 32'h11110001;
    cycle();
    o_ready = 1'b0; i_data = 32'h33331234;
    cycle();
    i_data = 32'hDEADBEEF;
    tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL capture_i_ready: got %b expected 0", i_ready); end
    tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("FAIL capture_o_valid: got %b expected 1", o_valid); end
    tests_run++; if (o_data !== 32'h11110001) begin tests_failed++; $display("FAIL capture_o_data: got %h expected 11110001", o_data); end
    cycle();
    tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL full_i_ready: got %b expected 0", i_ready); end
    tests_run++; if (o_data !== 32'h11110001) begin tests_failed++; $display("FAIL full_hold: got %h expected 11110001", o_data); end
    i_valid = 1'b0; o_ready = 1'b1;
    cycle();
    tests_run++; if (o_data !== 32'h33331234) begin tests_failed++; $display("FAIL skid_out_data: got %h expected 33331234", o_data); end
    tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("FAIL skid_out_valid: got %b expected 1", o_valid); end
    tests_run++; if (i_ready !== 1'b1) begin tests_failed++; $display("FAIL skid_drain_ready: got %b expected 1", i_ready); end
    cycle();
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL capture_idle: got %b expected 0", o_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] beats[3];
    logic [31:0] got[$];
    int idx;
    bit hs_in;
    beats = '{32'h7777CCCC, 32'h0000CCCC, 32'h11112222};
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      o_ready = (c != 2);
      i_valid = (idx < 3);
      i_data  = (idx < 3) ? beats[idx] : 32'h0;
      hs_in   = i_valid && i_ready;
      if (o_valid && o_ready) got.push_back(o_data);
      cycle();
      if (hs_in) idx++;
    end
    i_valid = 1'b0;
    tests_run++; if (got.size() != 3) begin tests_failed++; $display("FAIL stream_count: got %0d expected 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= got.size()) begin tests_failed++; $display("FAIL stream_beat%0d: got none expected %h", k, beats[k]); end
      else if (got[k] !== beats[k]) begin tests_failed++; $display("FAIL stream_beat%0d: got %h expected %h", k, got[k], beats[k]); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp[3];
    logic [31:0] got[$];
    int acc_at;
    exp = '{32'hA0A0A0A0, 32'hB0B0B0B0, 32'h12369870};
    acc_at = -1;
    o_ready = 1'b1; i_valid = 1'b1; i_data = 32'hA0A0A0A0;
    cycle();
    o_ready = 1'b0; i_data = 32'hB0B0B0B0;
    cycle();
    i_data = 32'h12369870;
    cycle();
    tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_full_ready: got %b expected 0", i_ready); end
    tests_run++; if (o_data !== 32'hA0A0A0A0) begin tests_failed++; $display("FAIL flush_full_data: got %h expected a0a0a0a0", o_data); end
    o_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (o_valid && o_ready) got.push_back(o_data);
      if (i_valid && i_ready && acc_at < 0) acc_at = c;
      cycle();
      if (acc_at >= 0) i_valid = 1'b0;
    end
    tests_run++; if (acc_at != 1) begin tests_failed++; $display("FAIL flush_accept_cycle: got %0d expected 1", acc_at); end
    tests_run++; if (got.size() != 3) begin tests_failed++; $display("FAIL flush_count: got %0d expected 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= got.size()) begin tests_failed++; $display("FAIL flush_beat%0d: got none expected %h", k, exp[k]); end
      else if (got[k] !== exp[k]) begin tests_failed++; $display("FAIL flush_beat%0d: got %h expected %h", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b1; i_valid = 1'b1; i_data = 32'hFFFFFFFF;
    cycle();
    tests_run++; if (o_data !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL b2b_first: got %h expected ffffffff", o_data); end
    o_ready = 1'b0; i_data = 32'h01234567;
    cycle();
    i_valid = 1'b0;
    tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_stall_valid: got %b expected 1", o_valid); end
    tests_run++; if (o_data !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL b2b_stall_data: got %h expected ffffffff", o_data); end
    o_ready = 1'b1;
    cycle();
    tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_valid: got %b expected 1", o_valid); end
    tests_run++; if (o_data !== 32'h01234567) begin tests_failed++; $display("FAIL b2b_second: got %h expected 01234567", o_data); end
    cycle();
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %b expected 0", o_valid); end
  endtask

  task automatic test_random();
    int ready_pct;
    for (int c = 0; c < 400; c++) begin
      ready_pct = (c < 130) ? 90 : (c < 260) ? 30 : 60;
      i_valid = ($urandom_range(0, 99) < 70);
      i_data  = $urandom;
      o_ready = ($urandom_range(0, 99) < ready_pct);
      cycle();
      tests_run++;
      if (o_valid !== (mq.size() != 0)) begin tests_failed++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, o_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        tests_run++;
        if (o_data !== mq[0]) begin tests_failed++; $display("FAIL rand_data c=%0d: got %h expected %h", c, o_data, mq[0]); end
      end
      tests_run++;
      if (i_ready !== exp_ready()) begin tests_failed++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, i_ready, exp_ready()); end
    end
    i_valid = 1'b0; o_ready = 1'b1;
    cycle(); cycle(); cycle();
    tests_run++; if (o_valid !== 1'b0 || mq.size() != 0) begin tests_failed++; $display("FAIL rand_drain: got o_valid=%b model=%0d expected 0/0", o_valid, mq.size()); end
  endtask

  task automatic test_reset_full();
    o_ready = 1'b1; i_valid = 1'b1; i_data = 32'hC0C0C0C0;
    cycle();
    o_ready = 1'b0; i_data = 32'hD0D0D0D0;
    cycle();
    i_valid = 1'b0;
    tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL rstfull_pre_ready: got %b expected 0", i_ready); end
`ifdef SKID_STATS_EN
    tests_run++; if (stat_in_cnt !== m_in) begin tests_failed++; $display("FAIL stat_in: got %0d expected %0d", stat_in_cnt, m_in); end
    tests_run++; if (stat_out_cnt !== m_out) begin tests_failed++; $display("FAIL stat_out: got %0d expected %0d", stat_out_cnt, m_out); end
    tests_run++; if (stat_skid_cnt !== m_skid) begin tests_failed++; $display("FAIL stat_skid: got %0d expected %0d", stat_skid_cnt, m_skid); end
`endif
    #2;
    aresetn = 1'b1;
    #1;
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL rstfull_valid: got %b expected 0", o_valid); end
    tests_run++; if (o_data !== 32'h0) begin tests_failed++; $display("FAIL rstfull_data: got %h expected 00000000", o_data); end
    tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL rstfull_ready: got %b expected 0", i_ready); end
`ifdef SKID_STATS_EN
    tests_run++; if (stat_in_cnt !== 32'h0 || stat_out_cnt !== 32'h0 || stat_skid_cnt !== 32'h0) begin
      tests_failed++; $display("FAIL stat_clear: got %0d/%0d/%0d expected 0/0/0", stat_in_cnt, stat_out_cnt, stat_skid_cnt);
    end
`endif
    model_clear();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    o_ready = 1'b1;
    cycle();
    tests_run++; if (i_ready !== 1'b1) begin tests_failed++; $display("FAIL rstfull_recover_ready: got %b expected 1", i_ready); end
    i_valid = 1'b1; i_data = 32'h00000005;
    cycle();
    i_valid = 1'b0;
    tests_run++; if (o_data !== 32'h00000005) begin tests_failed++; $display("FAIL rstfull_new_beat: got %h expected 00000005", o_data); end
    cycle();
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL rstfull_no_stale: got %b expected 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_capture();
    test_stream();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
